// File: rtl/mole_scheduler_pkg.sv
// mole_scheduler shared types and constants.
// State enum, hole count and rnd byte field positions.
package mole_scheduler_pkg;

  localparam int NUM_HOLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_UP,
    ST_SHOW
  } state_t;

  // rnd byte fields: mole position, visible time, gap time
  localparam int POS_HI = 2;
  localparam int POS_LO = 0;
  localparam int UP_HI  = 3;
  localparam int UP_LO  = 0;
  localparam int GAP_HI = 6;
  localparam int GAP_LO = 4;

  // next mole position, never equal to the previous one
  function automatic logic [2:0] next_pos(
    input logic [2:0] p,
    input logic [2:0] prev
  );
    return (p == prev) ? p + 3'd1 : p;
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// mole_scheduler game-side bus.
// master drives enable/tick/rnd/btn_hit; slave drives mole and score outputs.
interface mole_scheduler_if;
  import mole_scheduler_pkg::*;

  logic                 enable;
  logic                 tick;
  logic [7:0]           rnd;
  logic [NUM_HOLES-1:0] btn_hit;
  logic [NUM_HOLES-1:0] mole_onehot;
  logic [2:0]           mole_idx;
  logic                 hit_flash;
  logic                 hit_pulse;
  logic                 miss_pulse;
  logic                 wrong_pulse;
  logic [7:0]           hit_count;
  logic [7:0]           miss_count;

  modport master (
    output enable, tick, rnd, btn_hit,
    input  mole_onehot, mole_idx, hit_flash,
    input  hit_pulse, miss_pulse, wrong_pulse,
    input  hit_count, miss_count
  );

  modport slave (
    input  enable, tick, rnd, btn_hit,
    output mole_onehot, mole_idx, hit_flash,
    output hit_pulse, miss_pulse, wrong_pulse,
    output hit_count, miss_count
  );

endinterface

// File: rtl/mole_scheduler_sat_counter8.sv
// sat_counter8: 8-bit up counter, sync reset, sticks at 255.
// Ports: clk, rst, inc (count enable), count.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= 8'd0;
    else if (inc && count != 8'hFF)
      count <= count + 8'd1;
  end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: picks mole hole, up/gap timing, resolves hits/misses.
// Ports: clk, rst (sync, active high), bus (slave side of mole_scheduler_if).
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int GAP_MIN    = 4,
  parameter int UP_MIN     = 8,
  parameter int SHOW_TICKS = 4,
  parameter int CNT_W      = 6
) (
  input logic            clk,
  input logic            rst,
  mole_scheduler_if.slave bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [2:0]           idx_q, idx_d;
  logic                 flash_q, flash_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 wrong_q, wrong_d;

  logic [CNT_W-1:0] gap_load;
  logic [CNT_W-1:0] up_load;
  logic [CNT_W-1:0] cnt_dec;
  logic [2:0]       pos;
  logic             hit;
  logic             last;
  logic             unused_rnd;

  assign unused_rnd = bus.rnd[7];

  assign gap_load = CNT_W'(GAP_MIN)
                  + CNT_W'(bus.rnd[GAP_HI:GAP_LO]);
  assign up_load  = CNT_W'(UP_MIN)
                  + CNT_W'(bus.rnd[UP_HI:UP_LO]);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign pos      = next_pos(bus.rnd[POS_HI:POS_LO], idx_q);
  assign hit      = |(bus.btn_hit & mole_q);
  assign last     = bus.tick && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mole_q  <= '0;
      idx_q   <= '0;
      flash_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mole_q  <= mole_d;
      idx_q   <= idx_d;
      flash_q <= flash_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wrong_q <= wrong_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mole_d  = mole_q;
    idx_d   = idx_q;
    flash_d = flash_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    wrong_d = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mole_d  = '0;
      flash_d = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          state_d = ST_GAP;
          cnt_d   = gap_load;
        end
        (state_q == ST_GAP): begin
          if (last) begin
            state_d = ST_UP;
            idx_d   = pos;
            mole_d  = NUM_HOLES'(1) << pos;
            cnt_d   = up_load;
          end else if (bus.tick) begin
            cnt_d = cnt_dec;
          end
        end
        (state_q == ST_UP): begin
          // a hit beats a same-cycle timeout
          if (hit) begin
            hit_d   = 1'b1;
            mole_d  = '0;
            flash_d = 1'b1;
            cnt_d   = CNT_W'(SHOW_TICKS);
            state_d = ST_SHOW;
          end else begin
            wrong_d = |bus.btn_hit;
            if (last) begin
              miss_d  = 1'b1;
              mole_d  = '0;
              cnt_d   = gap_load;
              state_d = ST_GAP;
            end else if (bus.tick) begin
              cnt_d = cnt_dec;
            end
          end
        end
        (state_q == ST_SHOW): begin
          if (last) begin
            flash_d = 1'b0;
            cnt_d   = gap_load;
            state_d = ST_GAP;
          end else if (bus.tick) begin
            cnt_d = cnt_dec;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  sat_counter8 u_hits (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_d),
    .count (bus.hit_count)
  );

  sat_counter8 u_misses (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_d),
    .count (bus.miss_count)
  );

  assign bus.mole_onehot = mole_q;
  assign bus.mole_idx    = idx_q;
  assign bus.hit_flash   = flash_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.wrong_pulse = wrong_q;

endmodule
